// File: rtl/mission_sequencer.sv
// mission_sequencer: runs NAVIGATE -> INSPECT -> TRANSMIT over NUM_TARGETS targets and captures per-target health.
// Define MISSION_SEQ_TIMEOUT_EN to compile in the per-state watchdog with retries (fault_code 2).
module mission_sequencer #(
    parameter int NUM_TARGETS    = 4,
    parameter int HEALTH_W       = 2,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRIES    = 2,
    localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            target_reached,
    input  logic                            inspection_complete,
    input  logic [HEALTH_W-1:0]             health_status_in,
    input  logic                            transmission_complete,
    input  logic                            finished,
    output logic [2:0]                      state_enc,
    output logic [IDX_W-1:0]                target_idx,
    output logic [NUM_TARGETS*HEALTH_W-1:0] health_status_out,
    output logic [1:0]                      fault_code,
    output logic                            mission_done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_NAVIGATE = 3'd1,
        S_INSPECT  = 3'd2,
        S_TRANSMIT = 3'd3,
        S_COMPLETE = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    localparam logic [1:0]       FC_NONE    = 2'd0;
    localparam logic [1:0]       FC_ABORT   = 2'd1;
    localparam logic [1:0]       FC_TIMEOUT = 2'd2;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_TARGETS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       fault_q, fault_d;
    logic             done_q, done_d;
    logic             health_clr, health_we;
    logic             stall, new_mission, advance, wd_expire;

    // A stall is an active state with neither its completion event nor abort this cycle.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            S_NAVIGATE: stall = !abort && !target_reached;
            S_INSPECT:  stall = !abort && !inspection_complete;
            S_TRANSMIT: stall = !abort && !transmission_complete;
            default:    stall = 1'b0;
        endcase
    end

    assign new_mission = (state_q == S_IDLE) && start;
    assign advance     = (state_q == S_TRANSMIT) && !abort && transmission_complete
                         && (idx_q != LAST_IDX);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        fault_d    = fault_q;
        done_d     = 1'b0;
        health_clr = 1'b0;
        health_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_NAVIGATE;
                    idx_d      = '0;
                    fault_d    = FC_NONE;
                    health_clr = 1'b1;
                end
            end
            S_NAVIGATE: begin
                if (abort) begin
                    state_d = S_FAULT;
                    fault_d = FC_ABORT;
                end else if (target_reached) begin
                    state_d = S_INSPECT;
                end else if (wd_expire) begin
                    state_d = S_FAULT;
                    fault_d = FC_TIMEOUT;
                end
            end
            S_INSPECT: begin
                if (abort) begin
                    state_d = S_FAULT;
                    fault_d = FC_ABORT;
                end else if (inspection_complete) begin
                    state_d   = S_TRANSMIT;
                    health_we = 1'b1;
                end else if (wd_expire) begin
                    state_d = S_FAULT;
                    fault_d = FC_TIMEOUT;
                end
            end
            S_TRANSMIT: begin
                if (abort) begin
                    state_d = S_FAULT;
                    fault_d = FC_ABORT;
                end else if (transmission_complete) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_COMPLETE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_NAVIGATE;
                        idx_d   = idx_q + 1'b1;
                    end
                end else if (wd_expire) begin
                    state_d = S_FAULT;
                    fault_d = FC_TIMEOUT;
                end
            end
            S_COMPLETE, S_FAULT: begin
                if (finished) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            fault_q <= FC_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fault_q <= fault_d;
            done_q  <= done_d;
        end
    end

    for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_slot
        logic [HEALTH_W-1:0] slot_q, slot_d;

        always_comb begin
            slot_d = slot_q;
            if (health_clr) begin
                slot_d = '0;
            end else if (health_we && (idx_q == IDX_W'(gi))) begin
                slot_d = health_status_in;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) slot_q <= '0;
            else        slot_q <= slot_d;
        end

        assign health_status_out[gi*HEALTH_W +: HEALTH_W] = slot_q;
    end

`ifdef MISSION_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRIES);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d;

    // Counter falls back to 0 whenever the state is left or re-entered after a retry.
    always_comb begin
        wd_cnt_d  = '0;
        retry_d   = retry_q;
        wd_expire = 1'b0;
        if (new_mission || advance) retry_d = '0;
        if (stall) begin
            if (wd_cnt_q != CNT_MAX) begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end else if (retry_q < RTY_MAX) begin
                retry_d = retry_q + 1'b1;
            end else begin
                wd_expire = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            retry_q  <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            retry_q  <= retry_d;
        end
    end
`else
    localparam int unused_wd_cfg = TIMEOUT_CYCLES + MAX_RETRIES;
    logic unused_wd_sig;
    assign unused_wd_sig = stall ^ new_mission ^ advance;
    assign wd_expire     = 1'b0;
`endif

    assign state_enc    = state_q;
    assign target_idx   = idx_q;
    assign fault_code   = fault_q;
    assign mission_done = done_q;

endmodule

// File: tb/tb_mission_sequencer.sv
// Directed, table-driven bench for mission_sequencer (3 targets, 8-cycle watchdog, 1 retry).
module tb_mission_sequencer;

    localparam int NT = 3;
    localparam int HW = 2;
    localparam int TO = 8;
    localparam int MR = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       target_reached = 1'b0;
    logic       inspection_complete = 1'b0;
    logic [1:0] health_status_in = 2'd0;
    logic       transmission_complete = 1'b0;
    logic       finished = 1'b0;
    logic [2:0] state_enc;
    logic [1:0] target_idx;
    logic [5:0] health_status_out;
    logic [1:0] fault_code;
    logic       mission_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mission_sequencer #(
        .NUM_TARGETS   (NT),
        .HEALTH_W      (HW),
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .abort                (abort),
        .target_reached       (target_reached),
        .inspection_complete  (inspection_complete),
        .health_status_in     (health_status_in),
        .transmission_complete(transmission_complete),
        .finished             (finished),
        .state_enc            (state_enc),
        .target_idx           (target_idx),
        .health_status_out    (health_status_out),
        .fault_code           (fault_code),
        .mission_done         (mission_done)
    );

    typedef struct {
        logic       st, ab, tr, ic, tc, fn;
        logic [1:0] hs;
        logic [2:0] e_st;
        logic [1:0] e_idx;
        logic [5:0] e_h;
        logic [1:0] e_fc;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic ab, input logic tr, input logic ic,
                                input logic [1:0] hs, input logic tc, input logic fn,
                                input logic [2:0] e_st, input logic [1:0] e_idx,
                                input logic [5:0] e_h, input logic [1:0] e_fc, input logic e_done);
        vec_t v;
        v.st = st; v.ab = ab; v.tr = tr; v.ic = ic; v.hs = hs; v.tc = tc; v.fn = fn;
        v.e_st = e_st; v.e_idx = e_idx; v.e_h = e_h; v.e_fc = e_fc; v.e_done = e_done;
        return v;
    endfunction

    task automatic drive(input logic st, input logic ab, input logic tr, input logic ic,
                         input logic [1:0] hs, input logic tc, input logic fn);
        start = st; abort = ab; target_reached = tr; inspection_complete = ic;
        health_status_in = hs; transmission_complete = tc; finished = fn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic st, input logic ab, input logic tr, input logic ic,
                        input logic [1:0] hs, input logic tc, input logic fn);
        drive(st, ab, tr, ic, hs, tc, fn);
        tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [1:0] idx,
                             input logic [5:0] h, input logic [1:0] fc, input logic dn);
        $display("%s: state=%0d idx=%0d health=%b fault=%0d done=%0b",
                 tag, state_enc, target_idx, health_status_out, fault_code, mission_done);
        check({tag, ".state"}, 32'(state_enc), 32'(st));
        check({tag, ".idx"}, 32'(target_idx), 32'(idx));
        check({tag, ".health"}, 32'(health_status_out), 32'(h));
        check({tag, ".fault"}, 32'(fault_code), 32'(fc));
        check({tag, ".done"}, 32'(mission_done), 32'(dn));
    endtask

    initial begin
        // Inputs:  st ab tr ic hs tc fn   Expected: state idx health fault done
        vecs.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, 3'd1, 2'd0, 6'd0,  2'd0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2'd0, 0, 0, 3'd1, 2'd0, 6'd0,  2'd0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2'd0, 0, 0, 3'd2, 2'd0, 6'd0,  2'd0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2'd1, 0, 0, 3'd3, 2'd0, 6'd1,  2'd0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2'd0, 1, 0, 3'd1, 2'd1, 6'd1,  2'd0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2'd0, 0, 0, 3'd2, 2'd1, 6'd1,  2'd0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2'd2, 0, 0, 3'd3, 2'd1, 6'd9,  2'd0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2'd0, 1, 0, 3'd1, 2'd2, 6'd9,  2'd0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2'd0, 0, 0, 3'd2, 2'd2, 6'd9,  2'd0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2'd3, 0, 0, 3'd3, 2'd2, 6'd57, 2'd0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2'd0, 1, 0, 3'd4, 2'd2, 6'd57, 2'd0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 2'd0, 0, 0, 3'd4, 2'd2, 6'd57, 2'd0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2'd0, 0, 1, 3'd0, 2'd2, 6'd57, 2'd0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2'd0, 0, 0, 3'd0, 2'd2, 6'd57, 2'd0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 2'd0, 0, 0, 3'd1, 2'd0, 6'd0,  2'd0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2'd0, 0, 0, 3'd2, 2'd0, 6'd0,  2'd0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2'd2, 0, 0, 3'd3, 2'd0, 6'd2,  2'd0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2'd0, 1, 0, 3'd1, 2'd1, 6'd2,  2'd0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2'd0, 0, 0, 3'd2, 2'd1, 6'd2,  2'd0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 2'd3, 0, 0, 3'd3, 2'd1, 6'd14, 2'd0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2'd0, 1, 0, 3'd5, 2'd1, 6'd14, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2'd0, 0, 1, 3'd0, 2'd1, 6'd14, 2'd1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, 3'd1, 2'd0, 6'd0,  2'd0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 2'd0, 0, 0, 3'd5, 2'd0, 6'd0,  2'd1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 2'd0, 0, 0, 3'd5, 2'd0, 6'd0,  2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2'd0, 0, 1, 3'd0, 2'd0, 6'd0,  2'd1, 0));

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 3'd0, 2'd0, 6'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].st, vecs[i].ab, vecs[i].tr, vecs[i].ic, vecs[i].hs, vecs[i].tc, vecs[i].fn);
            check_all($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_idx, vecs[i].e_h,
                      vecs[i].e_fc, vecs[i].e_done);
        end

`ifdef MISSION_SEQ_TIMEOUT_EN
        // Watchdog in NAVIGATE: one silent retry at cycle 8, FAULT after 16.
        step(1, 0, 0, 0, 2'd0, 0, 0);
        check_all("wd_start", 3'd1, 2'd0, 6'd0, 2'd0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            step(0, 0, 0, 0, 2'd0, 0, 0);
            check($sformatf("wd_nav_hold%0d", i), 32'(state_enc), 32'd1);
        end
        step(0, 0, 0, 0, 2'd0, 0, 0);
        check_all("wd_nav_fault", 3'd5, 2'd0, 6'd0, 2'd2, 1'b0);
        step(0, 0, 0, 0, 2'd0, 0, 1);
        check_all("wd_fault_ack", 3'd0, 2'd0, 6'd0, 2'd2, 1'b0);

        // Completion on the timeout cycle wins and consumes no retry.
        step(1, 0, 0, 0, 2'd0, 0, 0);
        step(0, 0, 1, 0, 2'd0, 0, 0);
        for (int i = 1; i <= 7; i++) step(0, 0, 0, 0, 2'd0, 0, 0);
        check("sim_insp_hold", 32'(state_enc), 32'd2);
        step(0, 0, 0, 1, 2'd3, 0, 0);
        check_all("sim_insp_done", 3'd3, 2'd0, 6'd3, 2'd0, 1'b0);
        for (int i = 1; i <= 8; i++) step(0, 0, 0, 0, 2'd0, 0, 0);
        check("sim_tx_retry", 32'(state_enc), 32'd3);
        for (int i = 1; i <= 8; i++) step(0, 0, 0, 0, 2'd0, 0, 0);
        check_all("sim_tx_fault", 3'd5, 2'd0, 6'd3, 2'd2, 1'b0);
        step(0, 0, 0, 0, 2'd0, 0, 1);

        // Retry budget is per target: used on target 0, fresh again on target 1.
        step(1, 0, 0, 0, 2'd0, 0, 0);
        for (int i = 1; i <= 8; i++) step(0, 0, 0, 0, 2'd0, 0, 0);
        step(0, 0, 1, 0, 2'd0, 0, 0);
        step(0, 0, 0, 1, 2'd1, 0, 0);
        step(0, 0, 0, 0, 2'd0, 1, 0);
        check_all("rty_adv", 3'd1, 2'd1, 6'd1, 2'd0, 1'b0);
        for (int i = 1; i <= 15; i++) step(0, 0, 0, 0, 2'd0, 0, 0);
        check("rty_t1_hold", 32'(state_enc), 32'd1);
        step(0, 0, 0, 0, 2'd0, 0, 0);
        check_all("rty_t1_fault", 3'd5, 2'd1, 6'd1, 2'd2, 1'b0);
        step(0, 0, 0, 0, 2'd0, 0, 1);
`else
        // Without the watchdog a state waits indefinitely.
        step(1, 0, 0, 0, 2'd0, 0, 0);
        for (int i = 1; i <= 100; i++) step(0, 0, 0, 0, 2'd0, 0, 0);
        check_all("nowd_hold", 3'd1, 2'd0, 6'd0, 2'd0, 1'b0);
        step(0, 1, 0, 0, 2'd0, 0, 0);
        check_all("nowd_abort", 3'd5, 2'd0, 6'd0, 2'd1, 1'b0);
        step(0, 0, 0, 0, 2'd0, 0, 1);
`endif

        // Asynchronous reset in the middle of INSPECT on target 2.
        step(1, 0, 0, 0, 2'd0, 0, 0);
        step(0, 0, 1, 0, 2'd0, 0, 0);
        step(0, 0, 0, 1, 2'd1, 0, 0);
        step(0, 0, 0, 0, 2'd0, 1, 0);
        step(0, 0, 1, 0, 2'd0, 0, 0);
        step(0, 0, 0, 1, 2'd2, 0, 0);
        step(0, 0, 0, 0, 2'd0, 1, 0);
        step(0, 0, 1, 0, 2'd0, 0, 0);
        check_all("rst_pre", 3'd2, 2'd2, 6'd9, 2'd0, 1'b0);
        drive(0, 0, 0, 0, 2'd0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("rst_async", 3'd0, 2'd0, 6'd0, 2'd0, 1'b0);
        step(1, 0, 0, 0, 2'd0, 0, 0);
        check_all("rst_held", 3'd0, 2'd0, 6'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 2'd0, 0, 0);
        check_all("rst_restart", 3'd1, 2'd0, 6'd0, 2'd0, 1'b0);
        step(0, 0, 1, 0, 2'd0, 0, 0);
        step(0, 0, 0, 1, 2'd1, 0, 0);
        check_all("rst_t0_insp", 3'd3, 2'd0, 6'd1, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
